// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch unit and its next-PC logic.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // Branch displacement in bytes: sign-extended word offset shifted left by 2.
  function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [25:0] jump_addr,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_target;

  // Priority mux; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc4           = pc + 32'd4;
    branch_target = pc4 + sext_word_offset(target[IMM_HI:IMM_LO]);
    next_pc       = pc4;
    if (jr)
      next_pc = {pc4[31:28], jump_addr, 2'b00};
    else if (jump)
      next_pc = {pc4[31:28], target, 2'b00};
    else if (branch && zero)
      next_pc = branch_target;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over
// a req/ack handshake and presents its decoded fields until the datapath retires it.
// Optional build macro IFU_PERF_CNT_EN adds retired/stall performance counters.
//
// state | meaning
// FETCH | drive imem_req with imem_addr=PC for one cycle
// WAIT  | wait for imem_ack; give up with a nop and sticky imem_err after WAIT_LIMIT cycles
// ISSUE | inst_valid high, fields stable; advance PC on exec_done
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        inst_valid,
  input  logic        exec_done,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [29:0] jalAddr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [25:0] jumpAddr,
  output logic [31:0] pc,
  output logic        imem_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // Counter only needs to reach WAIT_LIMIT-1; the limit cycle itself triggers the timeout.
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  fetch_state_e     state, state_nxt;
  logic [31:0]      inst;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic [31:0]      next_pc;

  next_pc_logic u_next_pc (
    .pc        (pc),
    .target    (inst[TARGET_HI:TARGET_LO]),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .jr        (jr),
    .jump_addr (jumpAddr),
    .next_pc   (next_pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state decode; ack and exec_done are only honoured in their own state.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      FETCH: state_nxt = WAIT;
      WAIT: begin
        if (imem_ack) begin
          state_nxt = ISSUE;
        end else if (wait_cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: if (exec_done) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // PC, instruction latch, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= {RESET_PC[31:2], 2'b00};
      inst     <= INST_NOP;
      wait_cnt <= '0;
      imem_err <= 1'b0;
    end else begin
      case (state)
        FETCH: wait_cnt <= '0;
        WAIT: begin
          if (imem_ack) begin
            inst <= imem_rdata;
          end else if (timeout) begin
            inst     <= INST_NOP;
            imem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ISSUE: if (exec_done) pc <= next_pc;
        default: ;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state == ISSUE && exec_done) retired_cnt <= retired_cnt + 32'd1;
      if (state == WAIT && !imem_ack)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

  // Request is suppressed while reset is held so the bus sees no fetch during reset.
  always_comb begin
    imem_req   = (state == FETCH) && !reset;
    imem_addr  = pc;
    inst_valid = (state == ISSUE);
    opcode     = inst[OPCODE_HI:OPCODE_LO];
    rs         = inst[RS_HI:RS_LO];
    rt         = inst[RT_HI:RT_LO];
    rd         = inst[RD_HI:RD_LO];
    imm16      = inst[IMM_HI:IMM_LO];
    funct      = inst[FUNCT_HI:FUNCT_LO];
    jalAddr    = pc[31:2] + 30'd1;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected PCs are queued when an
// instruction is retired and compared when the unit issues the next fetch.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        inst_valid;
  logic        exec_done;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [29:0] jalAddr;
  logic        branch, zero, jump, jr;
  logic [25:0] jumpAddr;
  logic [31:0] pc;
  logic        imem_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] pc_q[$];
  logic [31:0] cur_pc;

  instruction_fetch_unit #(.RESET_PC(32'h0040_0000), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .inst_valid(inst_valid),
    .exec_done(exec_done), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .rd(rd), .imm16(imm16), .jalAddr(jalAddr), .branch(branch), .zero(zero),
    .jump(jump), .jr(jr), .jumpAddr(jumpAddr), .pc(pc), .imem_err(imem_err)
`ifdef IFU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input logic [31:0] w);
    chk("opcode", 32'(opcode), 32'(w[31:26]));
    chk("rs",     32'(rs),     32'(w[25:21]));
    chk("rt",     32'(rt),     32'(w[20:16]));
    chk("rd",     32'(rd),     32'(w[15:11]));
    chk("imm16",  32'(imm16),  32'(w[15:0]));
    chk("funct",  32'(funct),  32'(w[5:0]));
  endtask

  // Called at a negedge; finds the FETCH cycle, acks on the lat-th WAIT cycle,
  // and checks the issued instruction.
  task automatic fetch_issue(input logic [31:0] rdata, input int lat);
    int n;
    logic [31:0] exp_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall0;
`endif
    n = 0;
    #1;
    while (!imem_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    exp_pc = (pc_q.size() > 0) ? pc_q.pop_front() : 32'hxxxx_xxxx;
    cur_pc = exp_pc;
    chk("imem_addr", imem_addr, exp_pc);
    chk("pc", pc, exp_pc);
`ifdef IFU_PERF_CNT_EN
    stall0 = stall_cnt;
`endif
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("req_low_wait", 32'(imem_req), 32'd0);
      imem_ack   = (i == lat);
      imem_rdata = (i == lat) ? rdata : 32'hDEAD_BEEF;
    end
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("inst_valid", 32'(inst_valid), 32'd1);
    check_fields(rdata);
    chk("jalAddr", 32'(jalAddr), (exp_pc + 32'd4) >> 2);
`ifdef IFU_PERF_CNT_EN
    chk("stall_delta", stall_cnt - stall0, 32'(lat - 1));
`endif
  endtask

  task automatic retire(input logic br, input logic zr, input logic jp, input logic jrr,
                        input logic [25:0] ja, input logic [31:0] exp_next);
`ifdef IFU_PERF_CNT_EN
    logic [31:0] ret0;
    ret0 = retired_cnt;
`endif
    branch = br; zero = zr; jump = jp; jr = jrr; jumpAddr = ja; exec_done = 1'b1;
    pc_q.push_back(exp_next);
    @(negedge clk);
    exec_done = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0; jumpAddr = '0;
    chk("valid_after_done", 32'(inst_valid), 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("retired_delta", retired_cnt - ret0, 32'd1);
`endif
  endtask

  task automatic hold(input int cycles, input logic [31:0] w);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_req", 32'(imem_req), 32'd0);
      check_fields(w);
      chk("hold_jal", 32'(jalAddr), (cur_pc + 32'd4) >> 2);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; imem_rdata = '0; imem_ack = 1'b0; exec_done = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0; jumpAddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_err", 32'(imem_err), 32'd0);
    check_fields(32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
`endif
    reset = 1'b0;
    pc_q.push_back(32'h0040_0000);

    // First fetch, ack on the first WAIT cycle.
    fetch_issue(32'h2128_0005, 1);
    chk("t1_rs", 32'(rs), 32'd9);
    chk("t1_rt", 32'(rt), 32'd8);
    chk("t1_imm", 32'(imm16), 32'h0005);
    retire(0, 0, 0, 0, 26'h0, 32'h0040_0004);

    fetch_issue(32'h0000_0008, 1);
    retire(0, 0, 0, 1, 26'h000_0004, 32'h0000_0010);        // jr
    fetch_issue(32'h1000_FFFE, 1);
    retire(1, 1, 0, 0, 26'h0, 32'h0000_000C);                // branch taken backwards
    fetch_issue(32'h0000_0000, 2);
    retire(0, 0, 0, 0, 26'h0, 32'h0000_0010);
    fetch_issue(32'h1000_FFFE, 1);
    retire(1, 0, 0, 0, 26'h0, 32'h0000_0014);                // branch not taken
    fetch_issue(32'h1000_FFF9, 3);
    retire(1, 1, 0, 0, 26'h0, 32'hFFFF_FFFC);                // branch below zero wraps
    fetch_issue(32'h0000_0020, 1);
    chk("jal_wrap", 32'(jalAddr), 32'h0000_0000);
    retire(0, 0, 0, 0, 26'h0, 32'h0000_0000);                // sequential wrap
    fetch_issue(32'h0000_0008, 1);
    retire(0, 0, 0, 1, 26'h3FF_FFFF, 32'h0FFF_FFFC);
    fetch_issue(32'h0000_0000, 1);
    retire(0, 0, 0, 0, 26'h0, 32'h1000_0000);

    // jr beats jump; fields held while exec_done is withheld.
    fetch_issue(32'h0800_0040, 1);
    chk("jal_1000", 32'(jalAddr), 32'h0400_0001);
    hold(10, 32'h0800_0040);
    retire(0, 0, 1, 1, 26'h000_0100, 32'h1000_0400);
    fetch_issue(32'h0800_0000, 1);
    retire(0, 0, 1, 0, 26'h0, 32'h1000_0000);
    fetch_issue(32'h0800_0040, 1);
    retire(1, 1, 1, 0, 26'h000_0100, 32'h1000_0100);         // jump beats taken branch

    // Timeout: no ack; exec_done during FETCH/WAIT must be ignored.
    n = 0;
    #1;
    while (!imem_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("to_req", 32'(imem_req), 32'd1);
    chk("to_addr", imem_addr, pc_q.size() > 0 ? pc_q.pop_front() : 32'hxxxx_xxxx);
    cur_pc = 32'h1000_0100;
    exec_done = 1'b1; jump = 1'b1; jr = 1'b1; jumpAddr = 26'h3FF_FFFF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) begin
        exec_done = 1'b0; jump = 1'b0; jr = 1'b0; jumpAddr = '0;
      end
      chk("to_err_pre", 32'(imem_err), 32'd0);
      chk("to_valid_pre", 32'(inst_valid), 32'd0);
      chk("to_pc_wait", pc, 32'h1000_0100);
    end
    @(negedge clk);
    chk("to_err", 32'(imem_err), 32'd1);
    chk("to_valid", 32'(inst_valid), 32'd1);
    check_fields(32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;             // late ack in ISSUE
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("late_ack_valid", 32'(inst_valid), 32'd1);
    check_fields(32'h0);
    retire(0, 0, 0, 0, 26'h0, 32'h1000_0104);
    fetch_issue(32'h0000_0020, 1);
    chk("err_sticky", 32'(imem_err), 32'd1);
    retire(0, 0, 0, 0, 26'h0, 32'h1000_0108);

    // Reset while in WAIT abandons the fetch and clears the error.
    n = 0;
    #1;
    while (!imem_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rw_addr", imem_addr, pc_q.size() > 0 ? pc_q.pop_front() : 32'hxxxx_xxxx);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_pc", pc, 32'h0040_0000);
    chk("rw_err", 32'(imem_err), 32'd0);
    chk("rw_valid", 32'(inst_valid), 32'd0);
    chk("rw_req", 32'(imem_req), 32'd0);
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;             // stale ack in FETCH
    pc_q.push_back(32'h0040_0000);
    fetch_issue(32'h8D09_0004, 1);
    retire(0, 0, 0, 0, 26'h0, 32'h0040_0004);
    fetch_issue(32'h0000_0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the single-cycle datapath: owns the PC, fetches one instruction per execution slot from instruction memory over a req/ack handshake, and splits it into register/immediate fields.
- Computes next PC from sequential, branch, jump, jal and jr controls returned by control/datapath; supplies the jal link address.
- One instruction in flight; no pipelining.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored.
- WAIT_LIMIT, 16, cycles in WAIT before `imem_err` asserts; minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  byte address = PC
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- imem_ack  in  1  one-cycle acknowledge
- inst_valid  out  1  decoded fields valid; held until exec_done
- exec_done  in  1  datapath finished current instruction; next-PC controls valid this cycle
- opcode  out  6  inst[31:26]
- funct  out  6  inst[5:0]
- rs, rt, rd  out  5 each  inst[25:21], [20:16], [15:11]
- imm16  out  16  inst[15:0]
- jalAddr  out  30  (PC+4)>>2, link word address
- branch  in  1  beq-type instruction
- zero  in  1  ALU zero flag
- jump  in  1  j/jal
- jr  in  1  jump register
- jumpAddr  in  26  register target word bits [27:2]
- pc  out  32  current PC
- imem_err  out  1  sticky: ack not received within WAIT_LIMIT

Behaviour:
- Reset, checked before everything else: state=FETCH; PC=RESET_PC with [1:0]=0; inst register=0; imem_req=0; inst_valid=0; imem_err=0; wait counter=0. Reset mid-handshake abandons the fetch; a late ack is ignored.
- FETCH: imem_req=1 and imem_addr=PC for exactly one cycle, then go to WAIT.
- WAIT:
  - imem_req=0; count cycles.
  - On imem_ack: latch imem_rdata and go to ISSUE.
  - When the counter reaches WAIT_LIMIT with no ack: set imem_err, load inst=0 (nop), go to ISSUE.
- ISSUE:
  - inst_valid=1; field outputs are driven from the latched inst and stay stable.
  - On exec_done: PC<=next_pc, inst_valid<=0, go to FETCH.
  - With no exec_done, hold indefinitely.
- Next-PC, with pc4=PC+4 (mod 2^32), evaluated only in the exec_done cycle. Priority, highest first:
  1. jr: {pc4[31:28], jumpAddr, 2'b00}
  2. jump: {pc4[31:28], inst[25:0], 2'b00}
  3. branch&zero: pc4 + (sign-extended imm16 << 2)
  4. otherwise: pc4
- Arithmetic wraps modulo 2^32: PC=FFFF_FFFC sequential -> 0000_0000.
- jalAddr = pc4[31:2], combinational from PC. It stays valid throughout ISSUE.
- exec_done or ack outside its expected state is ignored.
- imem_err clears only on reset.
- Throughput: 3 cycles per instruction with 1-cycle ack latency and immediate exec_done.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds out ports retired_cnt[31:0] (+1 per exec_done in ISSUE) and stall_cnt[31:0] (+1 per WAIT cycle without ack).
  - Both counters are 0 on reset and wrap on overflow.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package `mips_pkg`:
  - fetch state enum (FETCH, WAIT, ISSUE)
  - field bit-position constants (OPCODE_HI/LO, RS_HI/LO, etc.)
  - INST_NOP = 32'h0
- Natural sub-module `next_pc_logic`: purely combinational priority mux plus adders. FSM and registers stay in the top.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, ack on 2nd cycle: imem_addr=0040_0000, rdata=32'h2128_0005 -> rs=9, rt=8, imm16=0005, inst_valid=1 in cycle 3; after exec_done, next imem_addr=0040_0004.
- Branch taken: PC=0000_0010, imm16=16'hFFFE, branch=1, zero=1 at exec_done -> next PC=0000_000C. Same with zero=0 -> 0000_0014.
- Jump vs jr priority: PC=1000_0000, inst[25:0]=26'h000_0040, jumpAddr=26'h000_0100, jump=1, jr=1 -> next PC=1000_0400. jr=0 -> 1000_0100. jalAddr=0400_0001 throughout ISSUE.
- Wrap: PC=FFFF_FFFC, sequential -> PC=0000_0000.
- Timeout: WAIT_LIMIT=4, never ack -> imem_err=1 after 4 WAIT cycles, inst_valid=1 with all fields 0. A late ack in ISSUE is ignored. Reset asserted during WAIT -> next cycle state FETCH, PC=RESET_PC, imem_err=0.
- Stall hold: exec_done withheld 10 cycles -> inst_valid and fields stable, imem_req=0. With IFU_PERF_CNT_EN and 3-cycle ack latency: stall_cnt increments by 2 per fetch, retired_cnt increments by 1 per exec_done.
